// File: rtl/pipeline_sink.sv
// rtl/pipeline_sink.sv - FIFO sink for a stalled valid/data pipeline with backpressure and frame-last tagging
// Optional feature macro: PIPELINE_SINK_STALL_STATS_EN adds stall_cnt_out (saturating count of cycles with en_out = 0).
module pipeline_sink #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4,
   parameter int FRAME_LEN  = 8
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         flush_in,
   input  logic signed [DATA_WIDTH-1:0] src_data_in,
   input  logic                         src_valid_in,
   output logic                         en_out,
   output logic signed [DATA_WIDTH-1:0] dst_data_out,
   output logic                         dst_valid_out,
   input  logic                         dst_ready_in,
   output logic                         dst_last_out,
   output logic [$clog2(DEPTH):0]       level_out
`ifdef PIPELINE_SINK_STALL_STATS_EN
   ,
   output logic [31:0]                  stall_cnt_out
`endif
);

   localparam int AW  = $clog2(DEPTH);
   localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [FCW-1:0] LAST_CNT = FCW'(FRAME_LEN - 1);

   // Each entry holds {last, data}; contents are never reset.
   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         occ;
   logic [FCW-1:0]      frame_cnt;
   logic                push;
   logic                pop;
   logic                frame_last;

   // Backpressure comes only from registered occupancy, so the upstream
   // enable never depends combinationally on the consumer or the source.
   assign en_out        = (occ < FULL_LVL);
   assign push          = en_out & src_valid_in;
   assign pop           = dst_valid_out & dst_ready_in;
   assign frame_last    = (frame_cnt == LAST_CNT);
   assign dst_valid_out = (occ != '0);
   assign level_out     = occ;
   assign dst_data_out  = mem[rd_ptr][DATA_WIDTH-1:0];
   // Gate the stored flag so an empty FIFO never shows stale memory as last.
   assign dst_last_out  = dst_valid_out & mem[rd_ptr][DATA_WIDTH];

   // Pointer, occupancy and frame position bookkeeping; flush acts like reset.
   always_ff @(posedge clk) begin
      if (!arst_n || flush_in) begin
         occ       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + 1'b1;
            frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            occ <= occ + 1'b1;
         end else if (pop && !push) begin
            occ <= occ - 1'b1;
         end
      end
   end

   // Storage write; a word presented during flush or reset is dropped.
   always_ff @(posedge clk) begin
      if (push && arst_n && !flush_in) begin
         mem[wr_ptr] <= {frame_last, src_data_in};
      end
   end

`ifdef PIPELINE_SINK_STALL_STATS_EN
   // Count cycles where upstream is held, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (!arst_n || flush_in) begin
         stall_cnt_out <= '0;
      end else if (!en_out && (stall_cnt_out != '1)) begin
         stall_cnt_out <= stall_cnt_out + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_sink.sv
// tb/tb_pipeline_sink.sv - directed self-checking bench for pipeline_sink
module tb_pipeline_sink;

   logic               clk;
   logic               arst_n;
   logic               flush;
   logic signed [15:0] src_data;
   logic               src_valid;
   logic               en_out;
   logic signed [15:0] dst_data_out;
   logic               dst_valid_out;
   logic               dst_ready;
   logic               dst_last_out;
   logic [2:0]         level_out;
`ifdef PIPELINE_SINK_STALL_STATS_EN
   logic [31:0]        stall_cnt_out;
`endif

   int errors = 0;
   int checks = 0;

   pipeline_sink #(.DATA_WIDTH(16), .DEPTH(4), .FRAME_LEN(8)) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .flush_in     (flush),
      .src_data_in  (src_data),
      .src_valid_in (src_valid),
      .en_out       (en_out),
      .dst_data_out (dst_data_out),
      .dst_valid_out(dst_valid_out),
      .dst_ready_in (dst_ready),
      .dst_last_out (dst_last_out),
      .level_out    (level_out)
`ifdef PIPELINE_SINK_STALL_STATS_EN
      ,
      .stall_cnt_out(stall_cnt_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_d(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      chk(tag, {16'h0, obs}, {16'h0, exp});
   endtask

   logic [15:0] rx [6];
   int          rx_n;
   logic        rx_last_any;
   int          k;

   initial begin
      arst_n    = 1'b0;
      flush     = 1'b0;
      src_data  = '0;
      src_valid = 1'b0;
      dst_ready = 1'b0;
      tick();
      tick();
      arst_n = 1'b1;
      chk("rst_level", 32'(level_out), 32'd0);
      chk("rst_valid", 32'(dst_valid_out), 32'd0);
      chk("rst_last", 32'(dst_last_out), 32'd0);
      chk("rst_en", 32'(en_out), 32'd1);

      // Streaming frame 0..7 with consumer always ready
      dst_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         src_valid = 1'b1;
         src_data  = 16'(i);
         tick();
         chk_d("t1_data", dst_data_out, 16'(i));
         chk("t1_valid", 32'(dst_valid_out), 32'd1);
         chk("t1_last", 32'(dst_last_out), (i == 7) ? 32'd1 : 32'd0);
         chk("t1_level", 32'(level_out), 32'd1);
         chk("t1_en", 32'(en_out), 32'd1);
      end
      src_valid = 1'b0;
      tick();
      chk("t1_drain_valid", 32'(dst_valid_out), 32'd0);
      chk("t1_drain_level", 32'(level_out), 32'd0);

      // Backpressure: fill with 100..103, 104 is held upstream
      dst_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         src_valid = 1'b1;
         src_data  = 16'(100 + k);
         tick();
         k++;
      end
      chk("t2_full_level", 32'(level_out), 32'd4);
      chk("t2_full_en", 32'(en_out), 32'd0);
      src_data = 16'(100 + k);
      tick();
      tick();
      chk("t2_hold_level", 32'(level_out), 32'd4);
      chk_d("t2_hold_data", dst_data_out, 16'd100);
      chk("t2_hold_en", 32'(en_out), 32'd0);

      // Release: upstream model advances only when en_out allowed the shift
      dst_ready   = 1'b1;
      rx_n        = 0;
      rx_last_any = 1'b0;
      for (int c = 0; c < 20 && rx_n < 6; c++) begin
         if (k < 6) begin
            src_valid = 1'b1;
            src_data  = 16'(100 + k);
         end else begin
            src_valid = 1'b0;
         end
         if (dst_valid_out && dst_ready) begin
            rx[rx_n]    = dst_data_out;
            rx_last_any = rx_last_any | dst_last_out;
            rx_n++;
         end
         if (en_out && src_valid) k++;
         tick();
      end
      src_valid = 1'b0;
      chk("t2_rx_count", 32'(rx_n), 32'd6);
      for (int j = 0; j < 6; j++) begin
         chk_d("t2_rx_data", (j < rx_n) ? rx[j] : 16'hDEAD, 16'(100 + j));
      end
      chk("t2_rx_last", 32'(rx_last_any), 32'd0);
      chk("t2_empty", 32'(dst_valid_out), 32'd0);

      // Bubbles discarded; frame counter is at 6 so -2 lands on position 7
      dst_ready = 1'b0;
      src_valid = 1'b1; src_data = -16'sd1;    tick();
      src_valid = 1'b0; src_data = 16'h5A5A;   tick();
      src_valid = 1'b1; src_data = -16'sd2;    tick();
      src_valid = 1'b0; src_data = 16'h1234;   tick();
      chk("t3_level", 32'(level_out), 32'd2);
      chk_d("t3_data0", dst_data_out, 16'hFFFF);
      chk("t3_last0", 32'(dst_last_out), 32'd0);
      dst_ready = 1'b1;
      tick();
      chk_d("t3_data1", dst_data_out, 16'hFFFE);
      chk("t3_last1", 32'(dst_last_out), 32'd1);
      chk("t3_level1", 32'(level_out), 32'd1);
      tick();
      chk("t3_empty", 32'(dst_valid_out), 32'd0);

      // Full, single pop, then push+pop keeps level constant
      dst_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         src_valid = 1'b1;
         src_data  = 16'(200 + i);
         tick();
      end
      chk("t4_full", 32'(level_out), 32'd4);
      chk("t4_en0", 32'(en_out), 32'd0);
      dst_ready = 1'b1;
      src_data  = 16'd204;
      tick();
      chk("t4_one_pop_level", 32'(level_out), 32'd3);
      chk("t4_en1", 32'(en_out), 32'd1);
      chk_d("t4_head", dst_data_out, 16'd201);
      tick();
      chk("t4_pp_level1", 32'(level_out), 32'd3);
      chk_d("t4_pp_head1", dst_data_out, 16'd202);
      src_data = 16'd205;
      tick();
      chk("t4_pp_level2", 32'(level_out), 32'd3);
      chk_d("t4_pp_head2", dst_data_out, 16'd203);

      // Flush with level 3 and a word presented: word dropped, frame restarts
      dst_ready = 1'b0;
      flush     = 1'b1;
      src_data  = 16'd300;
      tick();
      flush     = 1'b0;
      src_valid = 1'b0;
      chk("t5_level", 32'(level_out), 32'd0);
      chk("t5_valid", 32'(dst_valid_out), 32'd0);
      chk("t5_en", 32'(en_out), 32'd1);
      dst_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         src_valid = 1'b1;
         src_data  = 16'(400 + i);
         tick();
         chk_d("t5_data", dst_data_out, 16'(400 + i));
         chk("t5_last", 32'(dst_last_out), (i == 7) ? 32'd1 : 32'd0);
      end
      src_valid = 1'b0;
      tick();
      chk("t5_drain", 32'(level_out), 32'd0);

      // Stall statistics: fill, hold 10 cycles, flush
      dst_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         src_valid = 1'b1;
         src_data  = 16'(500 + i);
         tick();
      end
      src_valid = 1'b0;
      repeat (10) tick();
      chk("t6_level", 32'(level_out), 32'd4);
      chk("t6_en", 32'(en_out), 32'd0);
`ifdef PIPELINE_SINK_STALL_STATS_EN
      chk("t6_stall10", stall_cnt_out, 32'd10);
`endif
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t6_flush_level", 32'(level_out), 32'd0);
`ifdef PIPELINE_SINK_STALL_STATS_EN
      chk("t6_stall_clr", stall_cnt_out, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
